// File: rtl/acc_pkg.sv
// Shared definitions for the accumulation scheduler: datapath width, FSM encoding,
// default parameters and an index-width helper.
package acc_pkg;

   localparam int ACC_W           = 26;
   localparam int DEFAULT_N       = 4;
   localparam int DEFAULT_ADD_LAT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      WRITE = 2'd3
   } state_t;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/acc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr,
// wrapping modulo N, and returns it both one-hot and as an index.
module rr_arbiter
   import acc_pkg::*;
#(
   parameter int N     = DEFAULT_N,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   // Scan from farthest to nearest so the last hit is the highest-priority one.
   always_comb begin
      int cand;
      cand      = 0;
      grant     = '0;
      grant_idx = '0;
      for (int k = N; k >= 1; k--) begin
         cand = (int'(ptr) + k) % N;
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            grant_idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/acc_scheduler.sv
// Shares one external fixed-point adder among N accumulation channels,
// serving pending requests round-robin and writing each sum back after the adder latency.
module acc_scheduler
   import acc_pkg::*;
#(
   parameter int N       = DEFAULT_N,
   parameter int ADD_LAT = DEFAULT_ADD_LAT
) (
   input  logic                 clk,
   input  logic                 GlobalReset,
   input  logic [N-1:0]         req,
   input  logic [N*ACC_W-1:0]   increment,
   input  logic [N-1:0]         clr,
   output logic [N-1:0]         grant,
   output logic [N-1:0]         done,
   output logic [ACC_W-1:0]     add_a,
   output logic [ACC_W-1:0]     add_b,
   input  logic [ACC_W-1:0]     add_result,
   output logic [N*ACC_W-1:0]   acc_out,
   output logic                 busy
);

   localparam int IDX_W = idx_width(N);
   localparam int CNT_W = (ADD_LAT > 2) ? $clog2(ADD_LAT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((ADD_LAT > 1) ? ADD_LAT - 2 : 0);

   state_t             state, next_state;
   logic [IDX_W-1:0]   ch, ptr, arb_idx;
   logic [N-1:0]       arb_grant, ch_onehot;
   logic [ACC_W-1:0]   inc_q, sum_q;
   logic [CNT_W-1:0]   wait_cnt;
   logic               discard;
   logic [ACC_W-1:0]   acc     [N];
   logic [ACC_W-1:0]   inc_arr [N];

   rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
      .req       (req),
      .ptr       (ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   always_comb begin
      for (int i = 0; i < N; i++) begin
         inc_arr[i]                  = increment[i*ACC_W +: ACC_W];
         acc_out[i*ACC_W +: ACC_W]   = acc[i];
      end
   end

   assign ch_onehot = N'(1) << ch;
   assign add_a     = inc_q;
   assign add_b     = sum_q;

   always_ff @(posedge clk) begin
      if (!GlobalReset) state <= IDLE;
      else              state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (|arb_grant) next_state = ISSUE;
         ISSUE:   next_state = (ADD_LAT > 1) ? WAIT : WRITE;
         WAIT:    if (wait_cnt == WAIT_LAST) next_state = WRITE;
         WRITE:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      grant = '0;
      done  = '0;
      busy  = (state != IDLE);
      if (state == ISSUE) grant = ch_onehot;
      if (state == WRITE) done  = ch_onehot;
   end

   // A clear of the served channel anywhere from ISSUE onward voids its write-back.
   always_ff @(posedge clk) begin
      if (!GlobalReset) begin
         ch       <= '0;
         ptr      <= IDX_W'(N - 1);
         inc_q    <= '0;
         sum_q    <= '0;
         wait_cnt <= '0;
         discard  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|arb_grant) begin
                  ch      <= arb_idx;
                  inc_q   <= inc_arr[arb_idx];
                  sum_q   <= acc[arb_idx];
                  discard <= 1'b0;
               end
            end
            ISSUE: begin
               ptr      <= ch;
               wait_cnt <= '0;
               if (clr[ch]) discard <= 1'b1;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               if (clr[ch]) discard <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!GlobalReset)
            acc[i] <= '0;
         else if (clr[i])
            acc[i] <= '0;
         else if (state == WRITE && ch == IDX_W'(i) && !discard)
            acc[i] <= add_result;
      end
   end

endmodule

// File: tb/tb_acc_scheduler.sv
// Scoreboard bench for acc_scheduler: a behavioural model predicts grants, dones and sums,
// a negedge monitor checks whatever the DUT presents against those predictions.
module tb_acc_scheduler;
   import acc_pkg::*;

   localparam int N       = 4;
   localparam int ADD_LAT = 3;
   localparam int W       = ACC_W;

   typedef struct {
      int cyc;
      int ch;
   } ev_t;

   logic             clk = 1'b0;
   logic             GlobalReset;
   logic [N-1:0]     req, clr, grant, done;
   logic [N*W-1:0]   increment, acc_out;
   logic [W-1:0]     add_a, add_b, add_result;
   logic             busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   acc_scheduler #(.N(N), .ADD_LAT(ADD_LAT)) dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .req         (req),
      .increment   (increment),
      .clr         (clr),
      .grant       (grant),
      .done        (done),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_result  (add_result),
      .acc_out     (acc_out),
      .busy        (busy)
   );

   // Stand-in for the shared adder: ADD_LAT register stages.
   logic [W-1:0] pipe [ADD_LAT];
   always @(posedge clk) begin
      pipe[0] <= add_a + add_b;
      for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign add_result = pipe[ADD_LAT-1];

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: one service = selection, then ADD_LAT+1 busy cycles.
   int           cyc = 0;
   logic [W-1:0] m_acc [N];
   int           m_phase, m_ch, m_ptr;
   logic [W-1:0] m_inc, m_sum;
   bit           m_discard;
   ev_t          grant_q[$], done_q[$];
   int           grant_log[$], done_cyc_log[$];

   always @(posedge clk) begin
      cyc++;
      if (!GlobalReset) begin
         for (int i = 0; i < N; i++) m_acc[i] = '0;
         m_phase = 0; m_ch = 0; m_ptr = N - 1;
         m_inc = '0; m_sum = '0; m_discard = 0;
         grant_q.delete();
         done_q.delete();
      end else begin
         if (m_phase == 0) begin
            if (req != '0) begin
               int pick;
               pick = -1;
               for (int k = 1; k <= N; k++) begin
                  if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
               end
               m_ch = pick;
               m_inc = increment[pick*W +: W];
               m_sum = m_acc[pick];
               m_discard = 0;
               m_ptr = pick;
               m_phase = 1;
               grant_q.push_back('{cyc, pick});
               done_q.push_back('{cyc + ADD_LAT, pick});
            end
         end else begin
            if (clr[m_ch]) m_discard = 1;
            if (m_phase == ADD_LAT + 1) begin
               if (!m_discard) m_acc[m_ch] = m_inc + m_sum;
               m_phase = 0;
            end else begin
               m_phase++;
            end
         end
         for (int i = 0; i < N; i++) if (clr[i]) m_acc[i] = '0;
      end
   end

   function automatic logic [N*W-1:0] model_flat();
      logic [N*W-1:0] f;
      for (int i = 0; i < N; i++) f[i*W +: W] = m_acc[i];
      return f;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic logic [W-1:0] slot(input int i);
      return acc_out[i*W +: W];
   endfunction

   always @(negedge clk) begin
      if (cyc > 0) begin
         if (grant !== '0) begin
            grant_log.push_back(onehot_idx(grant));
            if (grant_q.size() == 0) check_output("grant_unexpected", 128'(grant), 128'(0));
            else begin
               ev_t e;
               e = grant_q.pop_front();
               check_output("grant_ch", 128'(grant), 128'(N'(1) << e.ch));
               check_output("grant_cycle", 128'(cyc), 128'(e.cyc));
            end
         end else if (grant_q.size() > 0 && grant_q[0].cyc <= cyc) begin
            ev_t e;
            e = grant_q.pop_front();
            check_output("grant_missing", 128'(grant), 128'(N'(1) << e.ch));
         end
         if (done !== '0) begin
            done_cyc_log.push_back(cyc);
            if (done_q.size() == 0) check_output("done_unexpected", 128'(done), 128'(0));
            else begin
               ev_t e;
               e = done_q.pop_front();
               check_output("done_ch", 128'(done), 128'(N'(1) << e.ch));
               check_output("done_cycle", 128'(cyc), 128'(e.cyc));
            end
         end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
            ev_t e;
            e = done_q.pop_front();
            check_output("done_missing", 128'(done), 128'(N'(1) << e.ch));
         end
         check_output("acc_out", 128'(acc_out), 128'(model_flat()));
         check_output("busy", 128'(busy), 128'(m_phase != 0));
         if (m_phase != 0) check_output("operands", 128'({add_a, add_b}), 128'({m_inc, m_sum}));
      end
   end

   task automatic apply_reset(input int cycles);
      GlobalReset = 1'b0;
      req = '0;
      clr = '0;
      repeat (cycles) @(negedge clk);
      GlobalReset = 1'b1;
   endtask

   // Serve one request; clr_mask is pulsed during the first WAIT cycle.
   task automatic apply_stimulus(input int ch, input logic [W-1:0] inc, input logic [N-1:0] clr_mask);
      int since;
      bit ok;
      since = -1;
      ok = 0;
      increment[ch*W +: W] = inc;
      req[ch] = 1'b1;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(negedge clk);
         clr = '0;
         if (since >= 0) since++;
         if (grant[ch]) since = 0;
         if (since == 1) clr = clr_mask;
         if (done[ch]) begin
            req[ch] = 1'b0;
            ok = 1;
         end
      end
      check_output("serve_timeout", 128'(ok), 128'(1));
      @(negedge clk);
      clr = '0;
   endtask

   task automatic drain();
      bit idle;
      idle = 0;
      clr = '0;
      for (int t = 0; t < 100 && !idle; t++) begin
         @(negedge clk);
         req &= ~done;
         if (req == '0 && !busy) idle = 1;
      end
      check_output("drain_timeout", 128'(idle), 128'(1));
      @(negedge clk);
   endtask

   initial begin
      int ndone;
      bit seen;
      increment = '0;
      apply_reset(2);
      @(negedge clk);
      check_output("reset_acc", 128'(acc_out), 128'(0));
      check_output("reset_busy", 128'(busy), 128'(0));
      check_output("reset_grant", 128'(grant), 128'(0));

      repeat (3) apply_stimulus(2, 26'h0000005, '0);
      check_output("acc2_sum", 128'(slot(2)), 128'(26'h000000F));

      apply_stimulus(1, 26'h3FFFFFF, '0);
      apply_stimulus(1, 26'h0000002, '0);
      check_output("acc1_wrap", 128'(slot(1)), 128'(26'h0000001));

      // Fairness: all channels requesting continuously for eight services.
      apply_reset(1);
      @(negedge clk);
      grant_log.delete();
      done_cyc_log.delete();
      for (int i = 0; i < N; i++) increment[i*W +: W] = W'(1);
      req = '1;
      ndone = 0;
      for (int t = 0; t < 100 && ndone < 8; t++) begin
         @(negedge clk);
         if (done != '0) ndone++;
         if (ndone == 8) req = '0;
      end
      check_output("fair_timeout", 128'(ndone), 128'(8));
      @(negedge clk);
      check_output("fair_count", 128'(grant_log.size()), 128'(8));
      for (int k = 0; k < grant_log.size() && k < 8; k++)
         check_output("fair_order", 128'(grant_log[k]), 128'(k % N));
      for (int k = 1; k < done_cyc_log.size(); k++)
         check_output("done_spacing", 128'(done_cyc_log[k] - done_cyc_log[k-1]), 128'(ADD_LAT + 2));
      for (int i = 0; i < N; i++) check_output("fair_acc", 128'(slot(i)), 128'(2));

      apply_stimulus(0, 26'h0000007, 4'b0001);
      check_output("clr_own", 128'(slot(0)), 128'(0));
      apply_stimulus(0, 26'h0000004, 4'b1000);
      check_output("clr_other_acc0", 128'(slot(0)), 128'(4));
      check_output("clr_other_acc3", 128'(slot(3)), 128'(0));

      // Reset in the middle of an add, then check the pointer restarted at N-1.
      increment[1*W +: W] = W'(9);
      req[1] = 1'b1;
      seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (grant[1]) seen = 1;
      end
      check_output("midreset_grant", 128'(seen), 128'(1));
      @(negedge clk);
      GlobalReset = 1'b0;
      req = '0;
      @(negedge clk);
      check_output("midreset_busy", 128'(busy), 128'(0));
      check_output("midreset_acc", 128'(acc_out), 128'(0));
      check_output("midreset_done", 128'(done), 128'(0));
      GlobalReset = 1'b1;
      req = 4'b0110;
      seen = 0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (grant != '0) begin
            seen = 1;
            check_output("ptr_after_reset", 128'(grant), 128'(4'b0010));
         end
      end
      check_output("ptr_grant_seen", 128'(seen), 128'(1));
      drain();

      // Random traffic with occasional clears and early request drops.
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            increment[i*W +: W] = W'($urandom);
            if (done[i]) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(2) == 0) req[i] = 1'b1;
            else if (req[i] && $urandom_range(19) == 0) req[i] = 1'b0;
            clr[i] = ($urandom_range(15) == 0);
         end
      end
      drain();
      check_output("grant_q_empty", 128'(grant_q.size()), 128'(0));
      check_output("done_q_empty", 128'(done_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acc_scheduler.md
Name: acc_scheduler

Overview:
- Time-multiplexes one shared 26-bit fixed-point adder among N accumulation channels.
- Holds one running sum per channel and arbitrates pending increment requests round-robin.
- For each grant it issues the operands (increment, stored sum) to the adder, waits the adder latency, then writes the result back.
- Sits between the per-channel sample sources and the single FixedPointAdder instance; it replaces per-channel adders.

Parameters:
- N, 4, number of requesting channels (2..8).
- ACC_W, 26, accumulator and increment width in bits.
- ADD_LAT, 1, adder latency: cycles from operands applied to add_result valid (>=1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- GlobalReset  input  1  synchronous, active-low reset.
- req  input  N  per-channel accumulate request; level, held until matching done.
- increment  input  N*ACC_W  channel i increment at bits [i*ACC_W +: ACC_W].
- clr  input  N  per-channel synchronous clear of stored sum.
- grant  output  N  one-hot, one-cycle pulse in ISSUE for the served channel.
- done  output  N  one-hot, one-cycle pulse in WRITE for the served channel.
- add_a  output  ACC_W  adder Port1: latched increment.
- add_b  output  ACC_W  adder Port2: latched stored sum.
- add_result  input  ACC_W  adder output.
- acc_out  output  N*ACC_W  stored sums, channel i at [i*ACC_W +: ACC_W].
- busy  output  1  high when state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. GlobalReset is synchronous and active-low.
- Reset (GlobalReset==0 at posedge):
  - state=IDLE; all acc_out=0; grant=0; done=0; busy=0; add_a=0; add_b=0.
  - Round-robin pointer = N-1, so channel 0 has first priority.
  - Reset mid-operation abandons the in-flight add; no done is issued.
- FSM states: IDLE, ISSUE, WAIT, WRITE. All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- IDLE:
  - If req!=0, select the first set bit searching ptr+1, ptr+2, ... modulo N.
  - Latch ch, inc_q=increment[ch], sum_q=acc[ch]. Next state ISSUE.
  - If req==0, stay in IDLE.
- ISSUE (1 cycle): grant[ch]=1; add_a=inc_q; add_b=sum_q; ptr<=ch. Next state WAIT if ADD_LAT>1, else WRITE.
- WAIT: lasts ADD_LAT-1 cycles, counted by a counter. Then WRITE.
- WRITE (1 cycle):
  - acc[ch]<=add_result; done[ch]=1. Next state IDLE.
  - add_a/add_b are held stable from ISSUE through WRITE inclusive.
- Latency: req seen in IDLE at edge t gives grant high in cycle t+1 and done high in cycle t+1+ADD_LAT. Back-to-back service period is ADD_LAT+2 cycles.
- Requester protocol:
  - Deassert req in the cycle done is seen, or the request is re-served.
  - A req held continuously is served once per round-robin turn.
  - increment is sampled only at the IDLE->ISSUE edge.
- Arithmetic: unsigned/two's-complement wrap modulo 2^ACC_W, performed entirely by the adder. The block performs no saturation and no overflow flag.
- clr[i]:
  - Sets acc[i]=0 at the next edge in any state.
  - If i==ch and clr arrives between ISSUE and WRITE inclusive, the write-back is discarded and acc[i] stays 0. done still pulses.
  - clr and write-back on the same channel in the same cycle: clr wins.
- Fairness: with all req high, grant order is 0,1,2,...,N-1,0,...
- A channel whose req drops before selection is simply skipped.

Decomposition:
- Shared package acc_pkg:
  - ACC_W=26.
  - State encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, WRITE=2'd3.
  - Default N and ADD_LAT.
- One sub-module, rr_arbiter (N-bit request vector plus pointer in, one-hot grant plus index out), purely combinational. It is used for IDLE selection and is unit-tested separately.

Test Plan:
- Reset with GlobalReset=0 for 2 cycles, then release -> acc_out all 0, busy=0, grant=0.
- req[2]=1, increment[2]=26'h0000005, ADD_LAT=1 -> grant[2] at t+1, done[2] at t+2, acc_out[2]=5; repeat twice more gives 26'h000000F.
- All req high, each increment=1 -> grants in order 0,1,2,3,0; each done spaced ADD_LAT+2 cycles; after 8 services every acc=2.
- acc[1]=26'h3FFFFFF, increment[1]=2 -> acc_out[1]=26'h0000001 (wrap), done[1] pulses.
- clr[0] asserted during WAIT of a channel-0 add (ADD_LAT=3) -> done[0] pulses, acc_out[0]=0. Simultaneous clr[3] during a channel-0 add -> acc[3]=0, and acc[0] updates normally.
- GlobalReset=0 during WAIT -> next cycle state IDLE, no done, all acc_out=0; the next req[1] gets grant before req[2] (pointer reset to N-1).
